// File: rtl/xlr8_pm_loader_if.sv
// Byte-stream and program-memory port bundle for the PM loader.
// The master modport is the loader's view; the slave modport is the byte source / PM view.
interface xlr8_pm_loader_if #(
    parameter int unsigned CNT_W = 17
) ();
    logic             byte_vld;
    logic [7:0]       byte_data;
    logic             byte_rdy;
    logic             pm_ce;
    logic             pm_wr;
    logic [CNT_W-1:0] pm_addr;
    logic [15:0]      pm_wr_data;
    logic [15:0]      pm_rd_data;

    modport master (
        input  byte_vld,
        input  byte_data,
        output byte_rdy,
        output pm_ce,
        output pm_wr,
        output pm_addr,
        output pm_wr_data,
        input  pm_rd_data
    );

    modport slave (
        output byte_vld,
        output byte_data,
        input  byte_rdy,
        input  pm_ce,
        input  pm_wr,
        input  pm_addr,
        input  pm_wr_data,
        output pm_rd_data
    );
endinterface

// File: rtl/xlr8_pm_loader.sv
// Program-memory loader: packs a little-endian byte stream into 16-bit words and writes them
// sequentially to PM, with an optional per-word read-back verify.
module xlr8_pm_loader #(
    parameter int unsigned PM_SIZE = 16,
    parameter int unsigned CNT_W   = 17
) (
    input  logic                clk,
    input  logic                rst_flash,
    input  logic                start,
    input  logic [CNT_W-1:0]    start_addr,
    input  logic [CNT_W-1:0]    num_words,
    input  logic                verify_en,
    input  logic                abort,
    xlr8_pm_loader_if.master    bus,
    output logic                busy,
    output logic                done,
    output logic                err_verify,
    output logic                err_range
);

    localparam logic [CNT_W-1:0] MaxAddr = CNT_W'(PM_SIZE * 1024 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLo,
        StHi,
        StWr,
        StRd,
        StCmp,
        StNxt
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             verify_q;
    logic [7:0]       lo_q;

    logic [CNT_W-1:0] addr_inc;
    logic             byte_hs;
    logic             last_word;

    assign addr_inc  = addr_q + CNT_W'(1);
    assign byte_hs   = bus.byte_vld & bus.byte_rdy;
    assign last_word = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst_flash) begin
        if (rst_flash) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            cnt_q          <= '0;
            verify_q       <= 1'b0;
            lo_q           <= '0;
            bus.byte_rdy   <= 1'b0;
            bus.pm_ce      <= 1'b0;
            bus.pm_wr      <= 1'b0;
            bus.pm_addr    <= '0;
            bus.pm_wr_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_verify     <= 1'b0;
            err_range      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        addr_q     <= start_addr;
                        cnt_q      <= num_words;
                        verify_q   <= verify_en;
                        err_verify <= 1'b0;
                        err_range  <= 1'b0;
                        if (num_words == '0) begin
                            done <= 1'b1;
                        end else if (start_addr > MaxAddr) begin
                            err_range <= 1'b1;
                        end else begin
                            state_q      <= StLo;
                            busy         <= 1'b1;
                            bus.byte_rdy <= 1'b1;
                        end
                    end
                end

                StLo: begin
                    if (abort) begin
                        state_q      <= StIdle;
                        busy         <= 1'b0;
                        bus.byte_rdy <= 1'b0;
                    end else if (byte_hs) begin
                        lo_q    <= bus.byte_data;
                        state_q <= StHi;
                    end
                end

                StHi: begin
                    if (abort) begin
                        state_q      <= StIdle;
                        busy         <= 1'b0;
                        bus.byte_rdy <= 1'b0;
                    end else if (byte_hs) begin
                        bus.byte_rdy   <= 1'b0;
                        bus.pm_ce      <= 1'b1;
                        bus.pm_wr      <= 1'b1;
                        bus.pm_addr    <= addr_q;
                        bus.pm_wr_data <= {bus.byte_data, lo_q};
                        state_q        <= StWr;
                    end
                end

                // The write always completes; abort is only honoured from the next state on.
                StWr: begin
                    bus.pm_wr <= 1'b0;
                    if (verify_q) begin
                        state_q <= StRd;
                    end else begin
                        bus.pm_ce <= 1'b0;
                        done      <= last_word;
                        state_q   <= StNxt;
                    end
                end

                StRd: begin
                    bus.pm_ce <= 1'b0;
                    state_q   <= StCmp;
                end

                StCmp: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (bus.pm_rd_data != bus.pm_wr_data) begin
                        err_verify <= 1'b1;
                        state_q    <= StIdle;
                        busy       <= 1'b0;
                    end else begin
                        done    <= last_word;
                        state_q <= StNxt;
                    end
                end

                // done was raised on entry when this was the last word; a finished load wins over abort.
                StNxt: begin
                    done   <= 1'b0;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    addr_q <= addr_inc;
                    if (last_word || abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (addr_inc > MaxAddr) begin
                        err_range <= 1'b1;
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                    end else begin
                        bus.byte_rdy <= 1'b1;
                        state_q      <= StLo;
                    end
                end

                default: begin
                    state_q      <= StIdle;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    bus.byte_rdy <= 1'b0;
                    bus.pm_ce    <= 1'b0;
                    bus.pm_wr    <= 1'b0;
                end
            endcase
        end
    end

    a_wr_needs_ce : assert property (@(posedge clk) disable iff (rst_flash)
        bus.pm_wr |-> bus.pm_ce);
    a_ce_in_access : assert property (@(posedge clk) disable iff (rst_flash)
        bus.pm_ce |-> (state_q inside {StWr, StRd}));
    a_busy_state : assert property (@(posedge clk) disable iff (rst_flash)
        busy == (state_q != StIdle));
    a_done_busy : assert property (@(posedge clk) disable iff (rst_flash)
        (done && busy) |-> (state_q == StNxt));

endmodule

// File: tb/tb_xlr8_pm_loader.sv
// Self-checking bench for xlr8_pm_loader: directed vector table, randomized loads against a
// word-level model, and abort / mid-load reset sequences.
module tb_xlr8_pm_loader;

    localparam int unsigned PmSize  = 16;
    localparam int unsigned CntW    = 17;
    localparam int          MaxAddr = PmSize * 1024 - 1;

    logic            clk = 1'b0;
    logic            rst_flash;
    logic            start;
    logic [CntW-1:0] start_addr;
    logic [CntW-1:0] num_words;
    logic            verify_en;
    logic            abort;
    logic            busy;
    logic            done;
    logic            err_verify;
    logic            err_range;

    xlr8_pm_loader_if #(.CNT_W(CntW)) bus ();

    xlr8_pm_loader #(
        .PM_SIZE (PmSize),
        .CNT_W   (CntW)
    ) dut (
        .clk        (clk),
        .rst_flash  (rst_flash),
        .start      (start),
        .start_addr (start_addr),
        .num_words  (num_words),
        .verify_en  (verify_en),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err_verify (err_verify),
        .err_range  (err_range)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Byte source: drives at negedge; a handshake is known at negedge because byte_rdy is registered.
    logic [7:0] src_q[$];
    int         gap_pct = 0;
    bit         hs_pending;

    initial begin
        bus.byte_vld  = 1'b0;
        bus.byte_data = 8'h00;
        hs_pending    = 1'b0;
        forever begin
            @(negedge clk);
            if (hs_pending && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
                bus.byte_vld  = 1'b1;
                bus.byte_data = src_q[0];
            end else begin
                bus.byte_vld = 1'b0;
            end
            hs_pending = bus.byte_vld && bus.byte_rdy;
        end
    end

    // PM model and access monitor.
    logic [15:0]     mem [0:131071];
    logic [CntW-1:0] wa_log[$];
    logic [15:0]     wd_log[$];
    int              cyc = 0;
    int              start_cyc = 0;
    int              done_cyc = 0;
    int              done_cnt = 0;
    int              rd_cnt = 0;
    int              rd_bad = 0;
    int              busy_cnt = 0;
    int              last_wr_cyc = -10;
    logic [CntW-1:0] last_wr_addr = '0;
    bit              rd_req = 1'b0;
    logic [15:0]     rd_val = 16'h0000;
    bit              corrupt_en = 1'b0;
    logic [CntW-1:0] corrupt_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            rd_req = 1'b0;
            if (!rst_flash) begin
                if (start && !busy) start_cyc = cyc;
                if (busy) busy_cnt++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (bus.pm_ce) begin
                    if (bus.pm_wr) begin
                        wa_log.push_back(bus.pm_addr);
                        wd_log.push_back(bus.pm_wr_data);
                        mem[bus.pm_addr] = bus.pm_wr_data;
                        last_wr_cyc      = cyc;
                        last_wr_addr     = bus.pm_addr;
                    end else begin
                        rd_cnt++;
                        if (!(cyc == last_wr_cyc + 1 && bus.pm_addr == last_wr_addr)) rd_bad++;
                        rd_req = 1'b1;
                        rd_val = (corrupt_en && bus.pm_addr == corrupt_addr) ? 16'hFFFF
                                                                             : mem[bus.pm_addr];
                    end
                end
            end
        end
    end

    initial begin
        bus.pm_rd_data = 16'h0000;
        forever begin
            @(posedge clk);
            if (rd_req) bus.pm_rd_data <= rd_val;
        end
    end

    // Results of the most recent do_load.
    int got_wbase, got_nwr, got_nrd, got_done, got_rdbad, got_busy;
    bit timed_out;

    task automatic do_load(input logic [CntW-1:0] a, input logic [CntW-1:0] n, input bit v,
                           input int gap);
        int wb, d0, r0, rb0, b0;
        wb  = wa_log.size();
        d0  = done_cnt;
        r0  = rd_cnt;
        rb0 = rd_bad;
        b0  = busy_cnt;
        gap_pct = gap;
        @(posedge clk); #1;
        start_addr = a;
        num_words  = n;
        verify_en  = v;
        start      = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        timed_out = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (busy) timed_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got_wbase = wb;
        got_nwr   = wa_log.size() - wb;
        got_nrd   = rd_cnt - r0;
        got_done  = done_cnt - d0;
        got_rdbad = rd_bad - rb0;
        got_busy  = busy_cnt - b0;
        src_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_errv"}, 32'(err_verify), 32'd0);
        chk({tag, "_errr"}, 32'(err_range), 32'd0);
        chk({tag, "_rdy"}, 32'(bus.byte_rdy), 32'd0);
        chk({tag, "_ce"}, 32'(bus.pm_ce), 32'd0);
        chk({tag, "_wr"}, 32'(bus.pm_wr), 32'd0);
        chk({tag, "_addr"}, 32'(bus.pm_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(bus.pm_wr_data), 32'd0);
    endtask

    typedef struct {
        logic [CntW-1:0] addr;
        logic [CntW-1:0] n;
        bit              v;
        bit              cor;
        logic [CntW-1:0] caddr;
        logic [63:0]     bytes;
        int              nwr;
        int              nrd;
        bit              dn;
        bit              ev;
        bit              er;
        int              lat;   // done cycle minus start cycle; 0 = not checked
        bit              bsy;
    } vec_t;

    vec_t tbl[6];

    initial begin : main
        logic [7:0]      rb[12];
        int              ea[$];
        logic [15:0]     ed[$];
        int              a, n, m, e_nrd, nb;
        bit              v, cor, e_dn, e_ev, e_er;
        logic [CntW-1:0] ca;
        logic [15:0]     w;

        tbl[0] = '{17'd0, 17'd2, 1'b0, 1'b0, 17'd0, 64'h0000_0000_005C_940C,
                   2, 0, 1'b1, 1'b0, 1'b0, 8, 1'b1};
        tbl[1] = '{17'd0, 17'd2, 1'b1, 1'b0, 17'd0, 64'h0000_0000_005C_940C,
                   2, 2, 1'b1, 1'b0, 1'b0, 12, 1'b1};
        tbl[2] = '{17'd0, 17'd3, 1'b1, 1'b1, 17'd1, 64'h0000_BEEF_005C_940C,
                   2, 2, 1'b0, 1'b1, 1'b0, 0, 1'b1};
        tbl[3] = '{17'h3FFF, 17'd2, 1'b0, 1'b0, 17'd0, 64'h0000_0000_1234_5678,
                   1, 0, 1'b0, 1'b0, 1'b1, 0, 1'b1};
        tbl[4] = '{17'h4000, 17'd1, 1'b0, 1'b0, 17'd0, 64'h0000_0000_0000_5678,
                   0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        tbl[5] = '{17'd5, 17'd0, 1'b0, 1'b0, 17'd0, 64'h0,
                   0, 0, 1'b1, 1'b0, 1'b0, 1, 1'b0};

        rst_flash  = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        num_words  = '0;
        verify_en  = 1'b0;
        abort      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_flash = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            corrupt_en   = tbl[i].cor;
            corrupt_addr = tbl[i].caddr;
            for (int b = 0; b < 2 * int'(tbl[i].n) && b < 8; b++) src_q.push_back(tbl[i].bytes[8*b +: 8]);
            do_load(tbl[i].addr, tbl[i].n, tbl[i].v, 0);
            chk($sformatf("v%0d_timeout", i), 32'(timed_out), 32'd0);
            chk($sformatf("v%0d_nwr", i), got_nwr, tbl[i].nwr);
            for (int k = 0; k < got_nwr && k < tbl[i].nwr; k++) begin
                chk($sformatf("v%0d_waddr%0d", i, k), 32'(wa_log[got_wbase+k]),
                    32'(tbl[i].addr) + k);
                chk($sformatf("v%0d_wdata%0d", i, k), 32'(wd_log[got_wbase+k]),
                    32'(tbl[i].bytes[16*k +: 16]));
            end
            chk($sformatf("v%0d_nrd", i), got_nrd, tbl[i].nrd);
            chk($sformatf("v%0d_rdorder", i), got_rdbad, 0);
            chk($sformatf("v%0d_done", i), got_done, 32'(tbl[i].dn));
            chk($sformatf("v%0d_errv", i), 32'(err_verify), 32'(tbl[i].ev));
            chk($sformatf("v%0d_errr", i), 32'(err_range), 32'(tbl[i].er));
            chk($sformatf("v%0d_busyseen", i), 32'(got_busy != 0), 32'(tbl[i].bsy));
            if (tbl[i].lat != 0) chk($sformatf("v%0d_latency", i), done_cyc - start_cyc, tbl[i].lat);
        end

        // Randomized loads against the word-level model.
        for (int it = 0; it < 30; it++) begin
            m = int'($urandom_range(3));
            case (m)
                0:       a = MaxAddr - int'($urandom_range(4));
                1:       a = int'($urandom_range(MaxAddr));
                2:       a = MaxAddr + int'($urandom_range(3, 1));
                default: a = int'($urandom_range(40));
            endcase
            n   = int'($urandom_range(6));
            v   = 1'($urandom_range(1));
            cor = v && ($urandom_range(1) == 1);
            ca  = CntW'(a + int'($urandom_range((n > 0) ? n - 1 : 0)));
            for (int b = 0; b < 2 * n; b++) begin
                rb[b] = 8'($urandom);
                src_q.push_back(rb[b]);
            end
            ea.delete();
            ed.delete();
            e_nrd = 0;
            e_dn  = 1'b0;
            e_ev  = 1'b0;
            e_er  = 1'b0;
            if (n == 0) begin
                e_dn = 1'b1;
            end else if (a > MaxAddr) begin
                e_er = 1'b1;
            end else begin
                e_dn = 1'b1;
                for (int k = 0; k < n; k++) begin
                    if (a + k > MaxAddr) begin
                        e_er = 1'b1;
                        e_dn = 1'b0;
                        break;
                    end
                    w = {rb[2*k+1], rb[2*k]};
                    ea.push_back(a + k);
                    ed.push_back(w);
                    if (v) begin
                        e_nrd++;
                        if (cor && CntW'(a + k) == ca && w != 16'hFFFF) begin
                            e_ev = 1'b1;
                            e_dn = 1'b0;
                            break;
                        end
                    end
                end
            end
            corrupt_en   = cor;
            corrupt_addr = ca;
            do_load(CntW'(a), CntW'(n), v, 30);
            chk($sformatf("r%0d_timeout", it), 32'(timed_out), 32'd0);
            chk($sformatf("r%0d_nwr", it), got_nwr, ea.size());
            for (int k = 0; k < got_nwr && k < ea.size(); k++) begin
                chk($sformatf("r%0d_waddr%0d", it, k), 32'(wa_log[got_wbase+k]), ea[k]);
                chk($sformatf("r%0d_wdata%0d", it, k), 32'(wd_log[got_wbase+k]), 32'(ed[k]));
            end
            chk($sformatf("r%0d_nrd", it), got_nrd, e_nrd);
            chk($sformatf("r%0d_rdorder", it), got_rdbad, 0);
            chk($sformatf("r%0d_done", it), got_done, 32'(e_dn));
            chk($sformatf("r%0d_errv", it), 32'(err_verify), 32'(e_ev));
            chk($sformatf("r%0d_errr", it), 32'(err_range), 32'(e_er));
        end
        corrupt_en = 1'b0;

        // Abort while stalled in HI of word 3 of 5: only words 0..2 may be written.
        nb = wa_log.size();
        m  = done_cnt;
        gap_pct = 40;
        for (int b = 0; b < 7; b++) begin
            rb[b] = 8'($urandom);
            src_q.push_back(rb[b]);
        end
        @(posedge clk); #1;
        start_addr = 17'd200;
        num_words  = 17'd5;
        verify_en  = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (wa_log.size() - nb == 3 && src_q.size() == 0 && bus.byte_rdy) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        chk("abort_reach_hi", 32'(timed_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_nwr", wa_log.size() - nb, 3);
        for (int k = 0; k < 3 && nb + k < wa_log.size(); k++) begin
            chk($sformatf("abort_waddr%0d", k), 32'(wa_log[nb+k]), 200 + k);
            chk($sformatf("abort_wdata%0d", k), 32'(wd_log[nb+k]), 32'({rb[2*k+1], rb[2*k]}));
        end
        chk("abort_done", done_cnt - m, 0);
        chk("abort_errv", 32'(err_verify), 32'd0);
        chk("abort_errr", 32'(err_range), 32'd0);
        src_q.delete();

        // Async reset in the middle of a later load; the loader must not resume.
        nb = wa_log.size();
        gap_pct = 30;
        for (int b = 0; b < 8; b++) src_q.push_back(8'($urandom));
        @(posedge clk); #1;
        start_addr = 17'd300;
        num_words  = 17'd4;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (wa_log.size() - nb >= 1) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst_first_write", 32'(timed_out), 32'd0);
        #3;
        rst_flash = 1'b1;
        #2;
        chk_zero("midrst");
        @(posedge clk); #1;
        rst_flash = 1'b0;
        nb = wa_log.size();
        m  = busy_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_resume_busy", busy_cnt - m, 0);
        chk("rst_no_resume_wr", wa_log.size() - nb, 0);
        src_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
